// File: rtl/axi_rd_burst_master.sv
// AXI4 read master: splits one user read into row-safe INCR bursts,
// forwards beats through a register and checks an incrementing pattern.
module axi_rd_burst_master #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32,
  parameter int COL_BITS   = 10,
  parameter int MAX_BURST  = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_end,
  input  logic                  rd_trig,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [LEN_WIDTH-1:0]  rd_len,
  input  logic                  chk_en,
  input  logic [DATA_WIDTH-1:0] chk_seed,
  output logic                  rd_ready,
  output logic                  rd_done,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_en,
  output logic                  rd_error,
  output logic [15:0]           rd_err_cnt,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  output logic [ADDR_WIDTH-1:0] axi_araddr,
  output logic [7:0]            axi_arlen,
  input  logic                  axi_rvalid,
  output logic                  axi_rready,
  input  logic                  axi_rlast,
  input  logic [1:0]            axi_rresp,
  input  logic [DATA_WIDTH-1:0] axi_rdata
);

  localparam int W1 = (LEN_WIDTH > COL_BITS + 1) ? LEN_WIDTH : COL_BITS + 1;
  localparam int CW = (W1 > 9) ? W1 : 9;

  typedef enum logic [2:0] {IDLE, CALC, AR, R, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  rem;
  logic                  chk;
  logic [DATA_WIDTH-1:0] exp_data;
  logic [8:0]            blen;
  logic [7:0]            bcnt;

  logic [CW-1:0]         row_w;
  logic [8:0]            blen_n;
  logic                  beat;
  logic                  beat_err;

  // Burst length limited by remaining beats, MAX_BURST and the row edge.
  always_comb begin
    row_w  = (CW'(1) << COL_BITS) - CW'(addr[COL_BITS-1:0]);
    blen_n = 9'(MAX_BURST);
    if (CW'(rem) < CW'(blen_n))
      blen_n = 9'(rem);
    if (row_w < CW'(blen_n))
      blen_n = 9'(row_w);
  end

  always_comb begin
    beat     = axi_rvalid && axi_rready;
    beat_err = (axi_rresp != 2'b00)
            || (axi_rlast != (bcnt == 8'd0))
            || (chk && (axi_rdata != exp_data));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rd_ready    <= 1'b1;
      rd_done     <= 1'b0;
      rd_data     <= '0;
      rd_data_en  <= 1'b0;
      rd_error    <= 1'b0;
      rd_err_cnt  <= '0;
      axi_arvalid <= 1'b0;
      axi_araddr  <= '0;
      axi_arlen   <= '0;
      axi_rready  <= 1'b0;
      addr        <= '0;
      rem         <= '0;
      chk         <= 1'b0;
      exp_data    <= '0;
      blen        <= '0;
      bcnt        <= '0;
    end else begin
      rd_done    <= 1'b0;
      rd_data_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rd_trig && init_end) begin
            addr       <= rd_addr;
            rem        <= rd_len;
            chk        <= chk_en;
            exp_data   <= chk_seed;
            rd_error   <= 1'b0;
            rd_err_cnt <= '0;
            rd_ready   <= 1'b0;
            if (rd_len == '0) begin
              rd_done <= 1'b1;
              state   <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          blen        <= blen_n;
          axi_araddr  <= addr;
          axi_arlen   <= 8'(blen_n - 9'd1);
          axi_arvalid <= 1'b1;
          state       <= AR;
        end
        AR: begin
          if (axi_arready) begin
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b1;
            bcnt        <= 8'(blen - 9'd1);
            state       <= R;
          end
        end
        R: begin
          if (beat) begin
            rd_data    <= axi_rdata;
            rd_data_en <= 1'b1;
            exp_data   <= exp_data + DATA_WIDTH'(1);
            if (beat_err) begin
              rd_error <= 1'b1;
              if (rd_err_cnt != 16'hFFFF)
                rd_err_cnt <= rd_err_cnt + 16'd1;
            end
            // Burst ends on our own count, not on rlast.
            if (bcnt == 8'd0) begin
              axi_rready <= 1'b0;
              addr       <= addr + ADDR_WIDTH'(blen);
              rem        <= rem - LEN_WIDTH'(blen);
              if (rem == LEN_WIDTH'(blen)) begin
                rd_done <= 1'b1;
                state   <= DONE;
              end else begin
                state <= CALC;
              end
            end else begin
              bcnt <= bcnt - 8'd1;
            end
          end
        end
        DONE: begin
          rd_ready <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_burst_master.sv
// Bench for axi_rd_burst_master: AXI slave model, AR/data scoreboards,
// one task per scenario.
module tb_axi_rd_burst_master;
  localparam int AW = 26;
  localparam int DW = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_end = 1'b0;
  logic          rd_trig = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [LW-1:0] rd_len = '0;
  logic          chk_en = 1'b0;
  logic [DW-1:0] chk_seed = '0;
  logic          rd_ready, rd_done, rd_data_en, rd_error;
  logic [DW-1:0] rd_data;
  logic [15:0]   rd_err_cnt;
  logic          axi_arvalid, axi_rready;
  logic [AW-1:0] axi_araddr;
  logic [7:0]    axi_arlen;
  logic          axi_arready = 1'b0;
  logic          axi_rvalid = 1'b0;
  logic          axi_rlast = 1'b0;
  logic [1:0]    axi_rresp = 2'b00;
  logic [DW-1:0] axi_rdata = '0;

  always #5 clk = ~clk;

  axi_rd_burst_master dut (
    .clk(clk), .rst(rst), .init_end(init_end), .rd_trig(rd_trig),
    .rd_addr(rd_addr), .rd_len(rd_len), .chk_en(chk_en),
    .chk_seed(chk_seed), .rd_ready(rd_ready), .rd_done(rd_done),
    .rd_data(rd_data), .rd_data_en(rd_data_en), .rd_error(rd_error),
    .rd_err_cnt(rd_err_cnt), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready), .axi_araddr(axi_araddr),
    .axi_arlen(axi_arlen), .axi_rvalid(axi_rvalid),
    .axi_rready(axi_rready), .axi_rlast(axi_rlast),
    .axi_rresp(axi_rresp), .axi_rdata(axi_rdata)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    l;
  } ar_t;

  int vectors = 0;
  int miscompares = 0;

  ar_t           exp_ar[$];
  ar_t           obs_ar[$];
  logic [DW-1:0] exp_dat[$];

  int            ar_delay = 0;
  bit            r_toggle = 1'b0;
  bit            tog = 1'b0;
  int            rresp_idx = -1;
  int            rlast_idx = -1;
  int            bad_idx = -1;
  logic [DW-1:0] dofs = 32'h1000_0000;

  bit            s_busy = 1'b0;
  logic [AW-1:0] s_addr = '0;
  int            s_left = 0;
  int            g_beat = 0;
  int            ar_wait = 0;
  int            stab_viol = 0;
  bit            ar_pend = 1'b0;
  ar_t           ar_last;

  int            n_en, done_c, first_ar, ready_wait;
  int            poke_c = -1;
  logic [AW-1:0] poke_addr = '0;
  bit            err_accept;

  // Slave: samples handshakes on the edge, drives new values 1 ns later.
  always @(posedge clk) begin
    if (rst) begin
      s_busy  = 1'b0;
      ar_wait = 0;
      ar_pend = 1'b0;
    end else begin
      if (ar_pend && (!axi_arvalid || {axi_araddr, axi_arlen} != ar_last))
        stab_viol++;
      ar_pend = axi_arvalid && !axi_arready;
      ar_last = '{axi_araddr, axi_arlen};
      if (axi_arvalid && axi_arready) begin
        obs_ar.push_back('{axi_araddr, axi_arlen});
        s_busy  = 1'b1;
        s_addr  = axi_araddr;
        s_left  = int'(axi_arlen) + 1;
        ar_wait = 0;
      end
      if (axi_rvalid && axi_rready) begin
        s_addr = s_addr + AW'(1);
        s_left--;
        g_beat++;
        if (s_left == 0) s_busy = 1'b0;
      end
    end
    #1;
    tog = ~tog;
    axi_arready = axi_arvalid && !s_busy && (ar_wait >= ar_delay);
    if (axi_arvalid && !axi_arready) ar_wait++;
    axi_rvalid = s_busy && (!r_toggle || tog);
    axi_rdata  = (g_beat == bad_idx) ? '0 : DW'(s_addr) + dofs;
    axi_rresp  = (g_beat == rresp_idx) ? 2'b10 : 2'b00;
    axi_rlast  = (s_left == 1) ^ (g_beat == rlast_idx);
  end

  task automatic model_cmd(input logic [AW-1:0] addr, input int len);
    logic [AW-1:0] a;
    logic [AW-1:0] x;
    int r, b, room;
    a = addr;
    r = len;
    while (r > 0) begin
      room = 1024 - int'(a[9:0]);
      b = (r < 16) ? r : 16;
      if (room < b) b = room;
      exp_ar.push_back('{a, 8'(b - 1)});
      a = a + AW'(b);
      r -= b;
    end
    for (int i = 0; i < len; i++) begin
      x = addr + AW'(i);
      exp_dat.push_back((i == bad_idx) ? '0 : DW'(x) + dofs);
    end
  endtask

  task automatic run_cmd(input logic [AW-1:0] addr, input int len,
                         input bit ce, input logic [DW-1:0] seed);
    logic [DW-1:0] e;
    ar_t ea, oa;
    ready_wait = 0;
    while (!rd_ready && ready_wait < 20) begin
      @(posedge clk); #1;
      ready_wait++;
    end
    model_cmd(addr, len);
    g_beat   = 0;
    n_en     = 0;
    done_c   = -1;
    first_ar = -1;
    rd_addr  = addr;
    rd_len   = LW'(len);
    chk_en   = ce;
    chk_seed = seed;
    rd_trig  = 1'b1;
    @(posedge clk); #1;
    rd_trig = 1'b0;
    for (int c = 0; c < 2000 && done_c < 0; c++) begin
      if (c == 0) err_accept = rd_error || (rd_err_cnt != 16'd0);
      if (axi_arvalid && first_ar < 0) first_ar = c;
      if (rd_data_en) begin
        n_en++;
        vectors++;
        if (exp_dat.size() == 0) begin
          miscompares++;
          $display("FAIL rd_data extra beat got=%h", rd_data);
        end else begin
          e = exp_dat.pop_front();
          if (rd_data !== e) begin
            miscompares++;
            $display("FAIL rd_data beat %0d got=%h exp=%h", n_en - 1, rd_data, e);
          end
        end
      end
      if (rd_done) done_c = c;
      if (done_c < 0) begin
        if (c == poke_c) begin
          rd_trig = 1'b1;
          rd_addr = poke_addr;
        end
        @(posedge clk); #1;
        rd_trig = 1'b0;
      end
    end
    vectors++;
    if (done_c < 0) begin
      miscompares++;
      $display("FAIL rd_done timeout addr=%h len=%0d", addr, len);
    end
    vectors++;
    if (exp_dat.size() != 0) begin
      miscompares++;
      $display("FAIL rd_data missing %0d beats", exp_dat.size());
    end
    exp_dat.delete();
    vectors++;
    if (obs_ar.size() != exp_ar.size()) begin
      miscompares++;
      $display("FAIL ar_count got=%0d exp=%0d", obs_ar.size(), exp_ar.size());
    end
    while (exp_ar.size() > 0 && obs_ar.size() > 0) begin
      ea = exp_ar.pop_front();
      oa = obs_ar.pop_front();
      vectors++;
      if (oa !== ea) begin
        miscompares++;
        $display("FAIL ar got=(%h,%0d) exp=(%h,%0d)", oa.a, oa.l, ea.a, ea.l);
      end
    end
    exp_ar.delete();
    obs_ar.delete();
  endtask

  task automatic test_reset();
    init_end = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({rd_ready, axi_arvalid, axi_rready, rd_done, rd_data_en, rd_error}
        !== 6'b100000) begin
      miscompares++;
      $display("FAIL reset_flags got=%b exp=100000",
        {rd_ready, axi_arvalid, axi_rready, rd_done, rd_data_en, rd_error});
    end
    vectors++;
    if (rd_err_cnt !== 16'd0 || rd_data !== '0) begin
      miscompares++;
      $display("FAIL reset_data cnt=%h data=%h exp=0", rd_err_cnt, rd_data);
    end
    vectors++;
    if ({axi_araddr, axi_arlen} !== '0) begin
      miscompares++;
      $display("FAIL reset_ar got=(%h,%h) exp=0", axi_araddr, axi_arlen);
    end
    rst = 1'b0;
  endtask

  task automatic test_split();
    run_cmd(26'h0, 40, 1'b0, '0);
    vectors++;
    if (n_en != 40 || rd_error !== 1'b0) begin
      miscompares++;
      $display("FAIL split beats=%0d err=%b exp=40,0", n_en, rd_error);
    end
    vectors++;
    if (first_ar != 1) begin
      miscompares++;
      $display("FAIL trig_to_ar got=%0d exp=1", first_ar);
    end
    @(posedge clk); #1;
    vectors++;
    if (rd_done !== 1'b0 || rd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL done_pulse done=%b ready=%b exp=0,1", rd_done, rd_ready);
    end
  endtask

  task automatic test_row();
    run_cmd(26'h3F8, 20, 1'b0, '0);
    vectors++;
    if (n_en != 20) begin
      miscompares++;
      $display("FAIL row beats got=%0d exp=20", n_en);
    end
    run_cmd(26'h3FF_FFF8, 12, 1'b0, '0);
  endtask

  task automatic test_check();
    dofs = 32'h100 - 32'h200;
    bad_idx = 5;
    run_cmd(26'h200, 8, 1'b1, 32'h100);
    vectors++;
    if (rd_error !== 1'b1 || rd_err_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL chk_bad err=%b cnt=%0d exp=1,1", rd_error, rd_err_cnt);
    end
    bad_idx = -1;
    run_cmd(26'h200, 8, 1'b1, 32'h100);
    vectors++;
    if (err_accept !== 1'b0 || rd_error !== 1'b0 || rd_err_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL chk_clear acc=%b err=%b cnt=%0d exp=0,0,0",
        err_accept, rd_error, rd_err_cnt);
    end
    bad_idx = 3;
    run_cmd(26'h200, 8, 1'b0, 32'h100);
    vectors++;
    if (rd_error !== 1'b0) begin
      miscompares++;
      $display("FAIL chk_off err=%b exp=0", rd_error);
    end
    bad_idx = -1;
    dofs = 32'h1000_0000;
  endtask

  task automatic test_resp();
    rresp_idx = 2;
    rlast_idx = 1;
    run_cmd(26'h40, 4, 1'b0, '0);
    vectors++;
    if (n_en != 4 || rd_error !== 1'b1 || rd_err_cnt !== 16'd2) begin
      miscompares++;
      $display("FAIL resp beats=%0d err=%b cnt=%0d exp=4,1,2",
        n_en, rd_error, rd_err_cnt);
    end
    rresp_idx = 3;
    rlast_idx = 3;
    run_cmd(26'h40, 4, 1'b0, '0);
    vectors++;
    if (rd_err_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL one_per_beat cnt=%0d exp=1", rd_err_cnt);
    end
    rresp_idx = -1;
    rlast_idx = -1;
  endtask

  task automatic test_stall();
    int bad;
    ar_delay  = 5;
    r_toggle  = 1'b1;
    stab_viol = 0;
    poke_c    = 12;
    poke_addr = 26'h3000;
    run_cmd(26'h10, 20, 1'b0, '0);
    vectors++;
    if (n_en != 20 || stab_viol != 0 || rd_error !== 1'b0) begin
      miscompares++;
      $display("FAIL stall beats=%0d viol=%0d err=%b exp=20,0,0",
        n_en, stab_viol, rd_error);
    end
    poke_c   = -1;
    ar_delay = 0;
    r_toggle = 1'b0;
    @(posedge clk); #1;
    init_end = 1'b0;
    rd_addr  = 26'h0;
    rd_len   = 16'd5;
    rd_trig  = 1'b1;
    bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (!rd_ready || axi_arvalid || rd_done) bad++;
    end
    rd_trig  = 1'b0;
    init_end = 1'b1;
    vectors++;
    if (bad != 0 || obs_ar.size() != 0) begin
      miscompares++;
      $display("FAIL init_block bad=%0d ars=%0d exp=0,0", bad, obs_ar.size());
    end
  endtask

  task automatic test_reset_mid();
    int w;
    rresp_idx = 0;
    g_beat  = 0;
    rd_addr = 26'h0;
    rd_len  = 16'd32;
    chk_en  = 1'b0;
    rd_trig = 1'b1;
    @(posedge clk); #1;
    rd_trig = 1'b0;
    w = 0;
    while (!axi_rready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (!axi_rready || rd_err_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL mid_pre rready=%b cnt=%0d exp=1,1", axi_rready, rd_err_cnt);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({axi_arvalid, axi_rready, rd_ready, rd_data_en} !== 4'b0010 ||
        rd_err_cnt !== 16'd0 || rd_data !== '0) begin
      miscompares++;
      $display("FAIL mid_reset flags=%b cnt=%0d data=%h exp=0010,0,0",
        {axi_arvalid, axi_rready, rd_ready, rd_data_en}, rd_err_cnt, rd_data);
    end
    rst = 1'b0;
    rresp_idx = -1;
    obs_ar.delete();
  endtask

  task automatic test_len0();
    run_cmd(26'h55, 0, 1'b0, '0);
    vectors++;
    if (done_c != 0 || n_en != 0 || first_ar != -1) begin
      miscompares++;
      $display("FAIL len0 done_c=%0d beats=%0d ar=%0d exp=0,0,-1",
        done_c, n_en, first_ar);
    end
  endtask

  task automatic test_back_to_back();
    run_cmd(26'h100, 3, 1'b0, '0);
    run_cmd(26'h200, 5, 1'b0, '0);
    vectors++;
    if (ready_wait != 1 || n_en != 5) begin
      miscompares++;
      $display("FAIL b2b wait=%0d beats=%0d exp=1,5", ready_wait, n_en);
    end
  endtask

  initial begin
    test_reset();
    test_split();
    test_row();
    test_check();
    test_resp();
    test_stall();
    test_reset_mid();
    test_len0();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
